// File: rtl/quadrature_decoder_ch_if.sv
// Decoder result bus: position, index, error and velocity outputs of quadrature_decoder_ch.
// The decoder drives the master side; the control loops read from the slave side.
interface quadrature_decoder_ch_if #(
  parameter int CNT_WIDTH = 32,
  parameter int VEL_WIDTH = 16,
  parameter int ERR_WIDTH = 8
);
  logic [CNT_WIDTH-1:0] position;
  logic                 step;
  logic                 direction;
  logic                 err;
  logic [ERR_WIDTH-1:0] err_count;
  logic                 index_pulse;
  logic [CNT_WIDTH-1:0] index_pos;
  logic [VEL_WIDTH-1:0] velocity;
  logic                 vel_valid;

  modport master (
    output position, step, direction, err, err_count,
           index_pulse, index_pos, velocity, vel_valid
  );

  modport slave (
    input position, step, direction, err, err_count,
          index_pulse, index_pos, velocity, vel_valid
  );
endinterface

// File: rtl/quadrature_decoder_ch.sv
// x4 quadrature decoder: A/B/Z synchronise and stability-filter, then position, index capture,
// illegal-transition tracking and windowed, saturating velocity.
module quadrature_decoder_ch #(
  parameter int CNT_WIDTH  = 32,
  parameter int FILTER_LEN = 4,
  parameter int VEL_WINDOW = 1000,
  parameter int VEL_WIDTH  = 16,
  parameter int ERR_WIDTH  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic Z,
  input  logic index_clr_en,
  input  logic err_clr,
  quadrature_decoder_ch_if.master dec
);

  localparam int FW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(VEL_WINDOW);
  localparam logic [VEL_WIDTH-1:0] VEL_MAX = {1'b0, {(VEL_WIDTH-1){1'b1}}};
  localparam logic [VEL_WIDTH-1:0] VEL_MIN = {1'b1, {(VEL_WIDTH-1){1'b0}}};

  // Bit order for the conditioned pins: [2]=Z, [1]=A, [0]=B
  logic [2:0]    pin;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    filt;
  logic [FW-1:0] flt_cnt [3];

  logic [1:0]    ab;
  logic [1:0]    prev_ab;
  logic          z_prev;
  logic          z_rise;
  logic          illegal;
  logic          valid;
  logic          up;

  logic [CNT_WIDTH-1:0] pos;
  logic                 step_r;
  logic                 dir_r;
  logic                 err_r;
  logic [ERR_WIDTH-1:0] err_cnt;
  logic                 idx_pulse_r;
  logic [CNT_WIDTH-1:0] idx_pos_r;

  logic [WW-1:0]        win_cnt;
  logic                 win_last;
  logic [VEL_WIDTH-1:0] acc;
  logic [VEL_WIDTH-1:0] acc_next;
  logic [VEL_WIDTH-1:0] vel_r;
  logic                 vel_valid_r;

  assign pin = {Z, A, B};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  // Filtered copy flips on the FILTER_LEN-th consecutive differing cycle, so the
  // counter only needs to reach FILTER_LEN-1 before the update edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= '0;
      for (int unsigned i = 0; i < 3; i++) flt_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i]    <= sync2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + FW'(1);
        end
      end
    end
  end

  assign ab      = filt[1:0];
  assign illegal = &(ab ^ prev_ab);
  assign valid   = ^(ab ^ prev_ab);
  assign z_rise  = filt[2] & ~z_prev;

  always_comb begin
    up = 1'b0;
    case ({prev_ab, ab})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: up = 1'b1;
      default:                                up = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ab     <= '0;
      z_prev      <= 1'b0;
      pos         <= '0;
      step_r      <= 1'b0;
      dir_r       <= 1'b0;
      idx_pulse_r <= 1'b0;
      idx_pos_r   <= '0;
    end else begin
      prev_ab     <= ab;
      z_prev      <= filt[2];
      step_r      <= valid;
      idx_pulse_r <= z_rise;
      if (valid) dir_r <= up;
      if (z_rise) idx_pos_r <= pos;
      // Index clear overrides a coincident step; the step still strobes and counts for velocity.
      if (z_rise && index_clr_en) begin
        pos <= '0;
      end else if (valid) begin
        pos <= up ? pos + CNT_WIDTH'(1) : pos - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_r   <= 1'b0;
      err_cnt <= '0;
    end else if (err_clr) begin
      err_r   <= illegal;
      err_cnt <= illegal ? ERR_WIDTH'(1) : '0;
    end else if (illegal) begin
      err_r <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + ERR_WIDTH'(1);
    end
  end

  always_comb begin
    acc_next = acc;
    if (valid && up && acc != VEL_MAX) begin
      acc_next = acc + VEL_WIDTH'(1);
    end else if (valid && !up && acc != VEL_MIN) begin
      acc_next = acc - VEL_WIDTH'(1);
    end
  end

  assign win_last = (win_cnt == WW'(VEL_WINDOW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt     <= '0;
      acc         <= '0;
      vel_r       <= '0;
      vel_valid_r <= 1'b0;
    end else begin
      vel_valid_r <= win_last;
      if (win_last) begin
        win_cnt <= '0;
        acc     <= '0;
        vel_r   <= acc_next;
      end else begin
        win_cnt <= win_cnt + WW'(1);
        acc     <= acc_next;
      end
    end
  end

  assign dec.position    = pos;
  assign dec.step        = step_r;
  assign dec.direction   = dir_r;
  assign dec.err         = err_r;
  assign dec.err_count   = err_cnt;
  assign dec.index_pulse = idx_pulse_r;
  assign dec.index_pos   = idx_pos_r;
  assign dec.velocity    = vel_r;
  assign dec.vel_valid   = vel_valid_r;

endmodule

// File: tb/tb_quadrature_decoder_ch.sv
// Directed bench for quadrature_decoder_ch: two instances share the pins, differing only in
// velocity width so saturation at VEL_WIDTH=4 can be checked alongside the 16-bit result.
module tb_quadrature_decoder_ch;
  localparam int CW  = 8;
  localparam int FL  = 4;
  localparam int VWN = 200;
  localparam int VW0 = 16;
  localparam int VW1 = 4;
  localparam int EW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic A = 1'b0, B = 1'b0, Z = 1'b0;
  logic index_clr_en = 1'b0;
  logic err_clr = 1'b0;

  int total = 0;
  int bad = 0;
  int step_cnt = 0;
  int idx_cnt = 0;
  int ph = 0;

  always #5 clk = ~clk;

  quadrature_decoder_ch_if #(.CNT_WIDTH(CW), .VEL_WIDTH(VW0), .ERR_WIDTH(EW)) dec0 ();
  quadrature_decoder_ch_if #(.CNT_WIDTH(CW), .VEL_WIDTH(VW1), .ERR_WIDTH(EW)) dec1 ();

  quadrature_decoder_ch #(
    .CNT_WIDTH(CW), .FILTER_LEN(FL), .VEL_WINDOW(VWN), .VEL_WIDTH(VW0), .ERR_WIDTH(EW)
  ) dut0 (
    .clk(clk), .rst(rst), .A(A), .B(B), .Z(Z),
    .index_clr_en(index_clr_en), .err_clr(err_clr), .dec(dec0)
  );

  quadrature_decoder_ch #(
    .CNT_WIDTH(CW), .FILTER_LEN(FL), .VEL_WINDOW(VWN), .VEL_WIDTH(VW1), .ERR_WIDTH(EW)
  ) dut1 (
    .clk(clk), .rst(rst), .A(A), .B(B), .Z(Z),
    .index_clr_en(index_clr_en), .err_clr(err_clr), .dec(dec1)
  );

  always @(negedge clk) begin
    if (dec0.step === 1'b1) step_cnt++;
    if (dec0.index_pulse === 1'b1) idx_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ph();
    case (ph)
      0:       {A, B} = 2'b00;
      1:       {A, B} = 2'b10;
      2:       {A, B} = 2'b11;
      default: {A, B} = 2'b01;
    endcase
  endtask

  task automatic edges(input int n, input bit up, input int hold);
    for (int i = 0; i < n; i++) begin
      ph = up ? (ph + 1) % 4 : (ph + 3) % 4;
      drive_ph();
      tick(hold);
    end
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_position"},    32'(dec0.position),    32'h0);
    chk({pfx, "_step"},        32'(dec0.step),        32'h0);
    chk({pfx, "_direction"},   32'(dec0.direction),   32'h0);
    chk({pfx, "_err"},         32'(dec0.err),         32'h0);
    chk({pfx, "_err_count"},   32'(dec0.err_count),   32'h0);
    chk({pfx, "_index_pulse"}, 32'(dec0.index_pulse), 32'h0);
    chk({pfx, "_index_pos"},   32'(dec0.index_pos),   32'h0);
    chk({pfx, "_velocity"},    32'(dec0.velocity),    32'h0);
    chk({pfx, "_vel_valid"},   32'(dec0.vel_valid),   32'h0);
  endtask

  task automatic wait_vv(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dec0.vel_valid !== 1'b1 && n < 300);
    chk(tag, 32'(dec0.vel_valid), 32'h1);
  endtask

  initial begin
    int vv;

    // Reset state
    tick(3);
    check_zero("reset");
    rst = 1'b0;
    tick(5);

    // Reverse through zero with 8-bit wrap, then back
    edges(3, 1'b0, 20);
    chk("rev3_position", 32'(dec0.position), 32'hFD);
    chk("rev3_direction", 32'(dec0.direction), 32'h0);
    edges(3, 1'b1, 20);
    chk("fwd3_position", 32'(dec0.position), 32'h00);

    // 8 forward quadrature cycles
    step_cnt = 0;
    edges(32, 1'b1, 20);
    chk("fwd32_position", 32'(dec0.position), 32'd32);
    chk("fwd32_steps", 32'(step_cnt), 32'd32);
    chk("fwd32_direction", 32'(dec0.direction), 32'h1);
    chk("fwd32_err", 32'(dec0.err), 32'h0);

    // 3-cycle glitch on A is filtered away
    A = 1'b1;
    tick(3);
    A = 1'b0;
    tick(20);
    chk("glitch_position", 32'(dec0.position), 32'd32);
    chk("glitch_steps", 32'(step_cnt), 32'd32);

    // Illegal 00 -> 11
    {A, B} = 2'b11;
    ph = 2;
    tick(20);
    chk("illegal_err", 32'(dec0.err), 32'h1);
    chk("illegal_err_count", 32'(dec0.err_count), 32'h1);
    chk("illegal_position", 32'(dec0.position), 32'd32);
    chk("illegal_steps", 32'(step_cnt), 32'd32);
    chk("illegal_direction", 32'(dec0.direction), 32'h1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    chk("errclr_err", 32'(dec0.err), 32'h0);
    chk("errclr_err_count", 32'(dec0.err_count), 32'h0);

    // Index with clear enabled at position 57
    edges(25, 1'b1, 20);
    chk("pre_index_position", 32'(dec0.position), 32'd57);
    idx_cnt = 0;
    index_clr_en = 1'b1;
    Z = 1'b1;
    tick(20);
    chk("index1_pos", 32'(dec0.index_pos), 32'd57);
    chk("index1_position", 32'(dec0.position), 32'd0);
    chk("index1_pulses", 32'(idx_cnt), 32'd1);
    Z = 1'b0;
    tick(20);
    index_clr_en = 1'b0;

    // Index with clear disabled: position keeps counting
    edges(5, 1'b1, 20);
    Z = 1'b1;
    tick(20);
    chk("index2_pos", 32'(dec0.index_pos), 32'd5);
    chk("index2_position", 32'(dec0.position), 32'd5);
    chk("index2_pulses", 32'(idx_cnt), 32'd2);
    edges(2, 1'b1, 20);
    chk("index2_keeps_counting", 32'(dec0.position), 32'd7);
    Z = 1'b0;
    tick(20);

    // Reset mid-operation at position 100
    edges(93, 1'b1, 8);
    chk("pre_reset_position", 32'(dec0.position), 32'd100);
    rst = 1'b1;
    tick(1);
    check_zero("midreset");
    {A, B} = 2'b00;
    ph = 0;
    tick(3);
    rst = 1'b0;
    vv = 0;
    repeat (VWN - 1) begin
      @(negedge clk);
      if (dec0.vel_valid === 1'b1) vv++;
    end
    chk("no_early_vel_valid", 32'(vv), 32'd0);
    @(negedge clk);
    chk("first_window_vel_valid", 32'(dec0.vel_valid), 32'h1);
    chk("first_window_velocity", 32'(dec0.velocity), 32'h0);

    // Velocity: +10, -4, then +12 (4-bit instance saturates at 7)
    edges(10, 1'b1, 8);
    wait_vv("win_p10_vel_valid");
    chk("win_p10_velocity", 32'(dec0.velocity), 32'h000A);
    chk("win_p10_velocity_sat4", 32'(dec1.velocity), 32'h7);
    edges(4, 1'b0, 10);
    wait_vv("win_m4_vel_valid");
    chk("win_m4_velocity", 32'(dec0.velocity), 32'hFFFC);
    chk("win_m4_velocity_w4", 32'(dec1.velocity), 32'hC);
    edges(12, 1'b1, 8);
    wait_vv("win_p12_vel_valid");
    chk("win_p12_velocity", 32'(dec0.velocity), 32'h000C);
    chk("win_p12_velocity_sat4", 32'(dec1.velocity), 32'h7);
    @(negedge clk);
    chk("vel_valid_one_cycle", 32'(dec0.vel_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
